// File: rtl/pulse_merge_sync_if.sv
// Bundle of the pulse-merge signals: toggle inputs a/b and the merged q with status.
// Optional cnt/drop outputs exist only when PULSE_MERGE_SYNC_CNT_EN is defined.
interface pulse_merge_sync_if;
  logic        a;
  logic        b;
  logic        q;
  logic        busy;
  logic        ovf;
`ifdef PULSE_MERGE_SYNC_CNT_EN
  logic [15:0] cnt;
  logic        drop;
`endif

  modport master (
    output a, output b,
    input  q, input  busy, input ovf
`ifdef PULSE_MERGE_SYNC_CNT_EN
    , input cnt, input drop
`endif
  );

  modport slave (
    input  a, input  b,
    output q, output busy, output ovf
`ifdef PULSE_MERGE_SYNC_CNT_EN
    , output cnt, output drop
`endif
  );
endinterface

// File: rtl/pulse_merge_sync.sv
// Merges two toggle-encoded pulse streams into one, spacing output toggles by MIN_GAP and
// queueing the backlog. Optional macro PULSE_MERGE_SYNC_CNT_EN adds the cnt and drop outputs.
module pulse_merge_sync #(
  parameter int PEND_W      = 2,
  parameter int MIN_GAP     = 3,
  parameter int INIT_CYCLES = 8
) (
  input logic             clk,
  input logic             rst_n,
  pulse_merge_sync_if.slave bus
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [INIT_W-1:0]   INIT_ONE  = INIT_W'(1);
  localparam logic [GAP_W-1:0]    GAP_ONE   = GAP_W'(1);
  localparam logic [PEND_W+1:0]   SUM_ONE   = (PEND_W + 2)'(1);
  localparam logic [PEND_W+1:0]   PEND_CAP  = {2'b00, {PEND_W{1'b1}}};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_GAP} state_t;

  state_t            state, state_nx;
  logic [PEND_W-1:0] pend, pend_nx;
  logic [INIT_W-1:0] init_cnt, init_cnt_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic              a_d, b_d;
  logic              q_r, busy_r, ovf_r;
  logic              emit, sat, busy_nx;
  logic [1:0]        ev;
  logic [PEND_W+1:0] tot, raw;

  assign ev  = {1'b0, bus.a ^ a_d} + {1'b0, bus.b ^ b_d};
  assign tot = {2'b00, pend} + {{PEND_W{1'b0}}, ev};

  // Raw pend is computed wide so an over-capacity result can be detected and clipped.
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    gap_cnt_nx  = gap_cnt;
    emit        = 1'b0;
    raw         = {2'b00, pend};
    case (state)
      S_INIT: begin
        init_cnt_nx = init_cnt - INIT_ONE;
        if (init_cnt <= INIT_ONE) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (tot != '0) begin
          emit = 1'b1;
          raw  = tot - SUM_ONE;
          if (MIN_GAP > 1) begin
            state_nx   = S_GAP;
            gap_cnt_nx = GAP_W'(MIN_GAP - 1);
          end
        end
      end
      S_GAP: begin
        raw        = tot;
        gap_cnt_nx = gap_cnt - GAP_ONE;
        if (gap_cnt <= GAP_ONE) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    sat     = (raw > PEND_CAP);
    pend_nx = sat ? {PEND_W{1'b1}} : raw[PEND_W-1:0];
    busy_nx = (state_nx != S_IDLE) | (pend_nx != '0);
  end

  // Input history reloads even in reset so the reset-time level is never seen as a pulse.
  always_ff @(posedge clk) begin
    a_d <= bus.a;
    b_d <= bus.b;
    if (!rst_n) begin
      state    <= (INIT_CYCLES == 0) ? S_IDLE : S_INIT;
      init_cnt <= INIT_W'(INIT_CYCLES);
      gap_cnt  <= '0;
      pend     <= '0;
      q_r      <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b1;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
      gap_cnt  <= gap_cnt_nx;
      pend     <= pend_nx;
      q_r      <= q_r ^ emit;
      ovf_r    <= ovf_r | sat;
      busy_r   <= busy_nx;
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;

`ifdef PULSE_MERGE_SYNC_CNT_EN
  logic [15:0] cnt_r;
  logic        drop_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= 16'd0;
      drop_r <= 1'b0;
    end else begin
      if (emit) cnt_r <= cnt_r + 16'd1;
      drop_r <= sat;
    end
  end

  assign bus.cnt  = cnt_r;
  assign bus.drop = drop_r;
`endif

endmodule
